adam_clk_divider: RTL and testbench

Synchronous power-of-two clock divider for the ADAM sequential domain. It takes the system `ADAM_SEQ` bundle (clock plus reset) and produces a derived `ADAM_SEQ` bundle whose clock runs at 1/2^WIDTH of the input frequency with 50 % duty cycle. It also produces a matching reset. It sits between the top-level clock/reset source and slower peripheral domains.

---
 rtl/adam_clk_div_pkg.sv | 14 +
 rtl/ADAM_SEQ.sv | 9 +
 rtl/adam_rst_sync.sv | 26 ++
 rtl/adam_clk_divider.sv | 58 +++++
 tb/tb_adam_clk_divider.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/adam_clk_div_pkg.sv
// Shared constants and helpers for the ADAM power-of-two clock divider.
// Build option: ADAM_CLK_DIV_RST_SYNC_EN enables the synchronized derived reset.
package adam_clk_div_pkg;

  localparam int WIDTH_MAX = 16;

  typedef logic [WIDTH_MAX-1:0] div_cnt_t;

  // Division ratio for a given counter width: 2^width.
  function automatic int unsigned div_ratio(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/ADAM_SEQ.sv
// ADAM sequential-domain bundle: one clock plus its active-low reset.
// Build option: none.
interface ADAM_SEQ;
  logic clk;
  logic rst;

  modport mst (output clk, output rst);
  modport slv (input clk, input rst);
endinterface

// File: rtl/adam_rst_sync.sv
// Two-stage enable-gated reset synchronizer for the divided domain.
// Build option: body exists only when ADAM_CLK_DIV_RST_SYNC_EN is defined.
`ifdef ADAM_CLK_DIV_RST_SYNC_EN
module adam_rst_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rst_n_sync
);
  import adam_clk_div_pkg::*;

  logic [1:0] sync_q;

  // Shift a one in on each enabled cycle; cleared while source reset is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else if (en) begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync = sync_q[1];

endmodule
`endif

// File: rtl/adam_clk_divider.sv
// Power-of-two 50% duty clock divider producing a derived ADAM_SEQ bundle.
// Build option: ADAM_CLK_DIV_RST_SYNC_EN aligns mst.rst release to mst.clk.
module adam_clk_divider
  import adam_clk_div_pkg::*;
#(
  parameter int WIDTH = 1
) (
  ADAM_SEQ.slv slv,
  ADAM_SEQ.mst mst
);

  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("adam_clk_divider: WIDTH must be within 1..16");
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             clk_q;
  logic             clk_nxt;

  // Next counter value and the divided clock level it implies.
  always_comb begin
    cnt_nxt = cnt + WIDTH'(1);
    clk_nxt = cnt_nxt[WIDTH-1];
  end

  // Free-running counter and clock flop; the wrap gives the falling edge.
  always_ff @(posedge slv.clk) begin
    if (!slv.rst) begin
      cnt   <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      clk_q <= clk_nxt;
    end
  end

  assign mst.clk = clk_q;

`ifdef ADAM_CLK_DIV_RST_SYNC_EN
  logic clk_rise;
  logic rst_sync;

  assign clk_rise = clk_nxt & ~clk_q;

  adam_rst_sync u_rst_sync (
    .clk        (slv.clk),
    .rst_n      (slv.rst),
    .en         (clk_rise),
    .rst_n_sync (rst_sync)
  );

  assign mst.rst = slv.rst & rst_sync;
`else
  assign mst.rst = slv.rst;
`endif

endmodule

// File: tb/tb_adam_clk_divider.sv
// Directed bench for adam_clk_divider at WIDTH 1, 2, 3 and 4.
// Build option: ADAM_CLK_DIV_RST_SYNC_EN switches the expected mst.rst.
`timescale 1ns/100ps
module tb_adam_clk_divider;
  import adam_clk_div_pkg::*;

  ADAM_SEQ src();
  ADAM_SEQ m1();
  ADAM_SEQ m2();
  ADAM_SEQ m3();
  ADAM_SEQ m4();

  adam_clk_divider #(.WIDTH(1)) u_w1 (.slv(src), .mst(m1));
  adam_clk_divider #(.WIDTH(2)) u_w2 (.slv(src), .mst(m2));
  adam_clk_divider #(.WIDTH(3)) u_w3 (.slv(src), .mst(m3));
  adam_clk_divider #(.WIDTH(4)) u_w4 (.slv(src), .mst(m4));

  int checks = 0;
  int errors = 0;

`ifdef ADAM_CLK_DIV_RST_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  initial src.clk = 1'b0;
  always #2.5 src.clk = ~src.clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge src.clk);
    @(negedge src.clk);
  endtask

  // Divided clock level k source edges after reset release.
  function automatic logic exp_clk(input int k, input int w);
    return ((k % div_ratio(w)) >= div_ratio(w - 1)) ? 1'b1 : 1'b0;
  endfunction

  // Derived reset level k edges after release (sync: 2nd divided rise).
  function automatic logic exp_rst(input int k, input int rel);
    if (!SYNC) return 1'b1;
    return (k >= rel) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    logic p1, p3, p4;
    int   r1, first3, fall3, rise3b;
    int   r4, last4, per4, run4, min4, tog4;

    src.rst = 1'b0;
    step();
    step();
    chk("rst_w1_clk", m1.clk, 0);
    chk("rst_w2_clk", m2.clk, 0);
    chk("rst_w3_clk", m3.clk, 0);
    chk("rst_w4_clk", m4.clk, 0);
    chk("rst_w1_rst", m1.rst, 0);
    chk("rst_w4_rst", m4.rst, 0);

    src.rst = 1'b1;
    #1;
    chk("rel_w1_rst", m1.rst, SYNC ? 0 : 1);
    chk("rel_w4_rst", m4.rst, SYNC ? 0 : 1);

    p1 = 0; p3 = 0; p4 = 0;
    r1 = 0; first3 = 0; fall3 = 0; rise3b = 0;
    r4 = 0; last4 = 0; per4 = 0; run4 = 0; min4 = 1000; tog4 = 0;

    for (int k = 1; k <= 520; k++) begin
      step();
      chk("w1_clk", m1.clk, exp_clk(k, 1));
      chk("w2_clk", m2.clk, exp_clk(k, 2));
      chk("w3_clk", m3.clk, exp_clk(k, 3));
      chk("w4_clk", m4.clk, exp_clk(k, 4));
      chk("w1_rst", m1.rst, exp_rst(k, 3));
      chk("w2_rst", m2.rst, exp_rst(k, 6));
      chk("w3_rst", m3.rst, exp_rst(k, 12));
      chk("w4_rst", m4.rst, exp_rst(k, 24));

      if (k <= 40 && m1.clk && !p1) r1++;
      if (m3.clk && !p3) begin
        if (first3 == 0) first3 = k;
        else if (rise3b == 0) rise3b = k;
      end
      if (!m3.clk && p3 && fall3 == 0) fall3 = k;

      if (m4.clk === p4) begin
        run4++;
      end else begin
        if (tog4 > 0 && run4 < min4) min4 = run4;
        tog4++;
        run4 = 1;
      end
      if (m4.clk && !p4) begin
        if (k <= 512) r4++;
        if (last4 != 0) per4 = k - last4;
        last4 = k;
      end

      p1 = m1.clk;
      p3 = m3.clk;
      p4 = m4.clk;
    end

    chk("w1_rises_200ns", r1, 20);
    chk("w3_first_rise", first3, 4);
    chk("w3_high_len", fall3 - first3, 4);
    chk("w3_period", rise3b - first3, 8);
    chk("w4_rises_32per", r4, 32);
    chk("w4_ratio", per4, 16);
    chk("w4_min_pulse", min4, 8);

    step();
    step();
    chk("mid_w2_high", m2.clk, 1);

    src.rst = 1'b0;
    #1;
    chk("ast_w1_rst", m1.rst, 0);
    chk("ast_w2_rst", m2.rst, 0);
    chk("ast_w3_rst", m3.rst, 0);
    chk("ast_w4_rst", m4.rst, 0);
    chk("ast_w2_clk_hold", m2.clk, 1);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("mid_w1_clk", m1.clk, 0);
      chk("mid_w2_clk", m2.clk, 0);
      chk("mid_w3_clk", m3.clk, 0);
      chk("mid_w4_clk", m4.clk, 0);
      chk("mid_w2_rst", m2.rst, 0);
    end

    src.rst = 1'b1;
    #1;
    chk("rel2_w2_rst", m2.rst, SYNC ? 0 : 1);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("rel2_w1_clk", m1.clk, exp_clk(j, 1));
      chk("rel2_w2_clk", m2.clk, exp_clk(j, 2));
      chk("rel2_w1_rst", m1.rst, exp_rst(j, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
